// File: rtl/latq_bank_pkg.sv
// Shared types and elaboration helpers for the latch-bank write controller.
package latq_bank_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2,
    HOLD  = 2'd3
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Phase counter width: clog2 of the longest phase, never below one bit.
  function automatic int cnt_w(input int s, input int w, input int h);
    int c;
    c = $clog2(max3(s, w, h));
    return (c < 1) ? 1 : c;
  endfunction

  // Every phase must last at least one cycle for the timing to hold.
  function automatic bit cyc_ok(input int s, input int w, input int h);
    return (s >= 1) && (w >= 1) && (h >= 1);
  endfunction

endpackage

// File: rtl/latq_bank_pulse_seq.sv
// Phase sequencer: IDLE -> SETUP -> PULSE -> HOLD -> IDLE, one down-counter.
module latq_bank_pulse_seq
  import latq_bank_pkg::*;
#(
  parameter int SETUP_CYC = 1,
  parameter int WIDTH_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   start,
  input  logic   in_range,
  output state_t phase,
  output logic   e_active,
  output logic   ready
);

  localparam int CW = cnt_w(SETUP_CYC, WIDTH_CYC, HOLD_CYC);
  localparam logic [CW-1:0] S_LD = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] W_LD = CW'(WIDTH_CYC - 1);
  localparam logic [CW-1:0] H_LD = CW'(HOLD_CYC - 1);

  if (!cyc_ok(SETUP_CYC, WIDTH_CYC, HOLD_CYC)) begin : g_bad_cyc
    $error("latq_bank_pulse_seq: every *_CYC value must be >= 1");
  end

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rng_q, rng_d;

  // State, phase counter and in-range flag of the in-flight write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rng_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rng_q   <= rng_d;
    end
  end

  // Next phase: counter reloads with length-1 on entry, phase ends at zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rng_d   = rng_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = SETUP;
        cnt_d   = S_LD;
        rng_d   = in_range;
      end
      SETUP: if (cnt_q == '0) begin
        state_d = PULSE;
        cnt_d   = W_LD;
      end else cnt_d = cnt_q - CW'(1);
      PULSE: if (cnt_q == '0) begin
        state_d = HOLD;
        cnt_d   = H_LD;
      end else cnt_d = cnt_q - CW'(1);
      HOLD: if (cnt_q == '0) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else cnt_d = cnt_q - CW'(1);
      default: state_d = IDLE;
    endcase
  end

  // PULSE is only reachable from SETUP/PULSE, so this never sees start.
  assign e_active = (state_d == PULSE) && rng_d;
  assign ready    = (state_q == IDLE);
  assign phase    = state_q;

endmodule

// File: rtl/latq_bank_ctrl.sv
// Latch-bank write/read controller: flop-driven LAT_E/LAT_D, registered read.
module latq_bank_ctrl
  import latq_bank_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 3,
  parameter int SETUP_CYC = 1,
  parameter int WIDTH_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    WR_VALID,
  output logic                    WR_READY,
  input  logic [ADDR_W-1:0]       WR_ADDR,
  input  logic [DATA_W-1:0]       WR_DATA,
  output logic                    WR_ERR,
  output logic [DATA_W-1:0]       LAT_D,
  output logic [DEPTH-1:0]        LAT_E,
  input  logic [DEPTH*DATA_W-1:0] LAT_Q,
  input  logic [ADDR_W-1:0]       RD_ADDR,
  output logic [DATA_W-1:0]       RD_DATA,
  output logic                    RD_STALE,
  output logic                    BUSY
);

  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);

  state_t            phase;
  logic              e_active, hs, in_rng;
  logic [ADDR_W-1:0] addr_q;
  logic [DEPTH-1:0]  dec_d, dec_q;
  logic [DATA_W-1:0] rd_word;

  assign hs     = WR_VALID && WR_READY;
  assign in_rng = {1'b0, WR_ADDR} < DEPTH_V;
  assign BUSY   = (phase != IDLE);

  latq_bank_pulse_seq #(
    .SETUP_CYC (SETUP_CYC),
    .WIDTH_CYC (WIDTH_CYC),
    .HOLD_CYC  (HOLD_CYC)
  ) u_seq (
    .clk      (CLK),
    .rst      (RST),
    .start    (hs),
    .in_range (in_rng),
    .phase    (phase),
    .e_active (e_active),
    .ready    (WR_READY)
  );

  // One-hot decode of the write address; out-of-range decodes to all zero.
  always_comb begin
    dec_d = '0;
    for (int i = 0; i < DEPTH; i++) dec_d[i] = (WR_ADDR == ADDR_W'(i));
  end

  // Capture the write and drive the latch pins; LAT_D moves only on a handshake.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      addr_q <= '0;
      dec_q  <= '0;
      LAT_D  <= '0;
      LAT_E  <= '0;
      WR_ERR <= 1'b0;
    end else begin
      if (hs) begin
        addr_q <= WR_ADDR;
        dec_q  <= dec_d;
        LAT_D  <= WR_DATA;
      end
      LAT_E  <= e_active ? dec_q : '0;
      WR_ERR <= hs && !in_rng;
    end
  end

  // Read mux over latch outputs; unmapped addresses read as zero.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < DEPTH; i++)
      if (RD_ADDR == ADDR_W'(i)) rd_word = LAT_Q[i*DATA_W +: DATA_W];
  end

  // Registered read data plus in-flight-write flag for the read address.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      RD_DATA  <= '0;
      RD_STALE <= 1'b0;
    end else begin
      RD_DATA  <= rd_word;
      RD_STALE <= (phase != IDLE) && (RD_ADDR == addr_q);
    end
  end

endmodule

// File: tb/tb_latq_bank_ctrl.sv
// Scoreboard bench: stimulus queues per-cycle expectations, monitor compares.
module tb_latq_bank_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // dut 0: defaults, dut 1: DEPTH=6, dut 2: SETUP=3 WIDTH=1 HOLD=2
  logic       wv_a, wv_b, wv_c;
  logic [2:0] wa_a, wa_b, wa_c, ra_a, ra_b, ra_c;
  logic [7:0] wd_a, wd_b, wd_c;
  logic       rdy_a, rdy_b, rdy_c, err_a, err_b, err_c;
  logic       st_a, st_b, st_c, busy_a, busy_b, busy_c;
  logic [7:0] d_a, d_b, d_c, rd_a, rd_b, rd_c;
  logic [7:0] e_a, e_c;
  logic [5:0] e_b;
  logic [63:0] q_a = '0;
  logic [47:0] q_b = 48'hF5F4F3F2F1F0;
  logic [63:0] q_c = '0;

  latq_bank_ctrl u_a (
    .CLK(clk), .RST(rst), .WR_VALID(wv_a), .WR_READY(rdy_a), .WR_ADDR(wa_a),
    .WR_DATA(wd_a), .WR_ERR(err_a), .LAT_D(d_a), .LAT_E(e_a), .LAT_Q(q_a),
    .RD_ADDR(ra_a), .RD_DATA(rd_a), .RD_STALE(st_a), .BUSY(busy_a));

  latq_bank_ctrl #(.DEPTH(6)) u_b (
    .CLK(clk), .RST(rst), .WR_VALID(wv_b), .WR_READY(rdy_b), .WR_ADDR(wa_b),
    .WR_DATA(wd_b), .WR_ERR(err_b), .LAT_D(d_b), .LAT_E(e_b), .LAT_Q(q_b),
    .RD_ADDR(ra_b), .RD_DATA(rd_b), .RD_STALE(st_b), .BUSY(busy_b));

  latq_bank_ctrl #(.SETUP_CYC(3), .WIDTH_CYC(1), .HOLD_CYC(2)) u_c (
    .CLK(clk), .RST(rst), .WR_VALID(wv_c), .WR_READY(rdy_c), .WR_ADDR(wa_c),
    .WR_DATA(wd_c), .WR_ERR(err_c), .LAT_D(d_c), .LAT_E(e_c), .LAT_Q(q_c),
    .RD_ADDR(ra_c), .RD_DATA(rd_c), .RD_STALE(st_c), .BUSY(busy_c));

  // Transparent latch array model for dut 0.
  always @(e_a or d_a)
    for (int i = 0; i < 8; i++) if (e_a[i]) q_a[i*8 +: 8] = d_a;

  typedef struct {
    int         id;
    logic [7:0] e;
    logic [7:0] d;
    logic       rdy;
    logic       err;
    logic       chk_rd;
    logic [7:0] rd;
    logic       st;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: one expected record per cycle, sampled 1 time unit after the edge.
  always begin : mon
    exp_t        x;
    logic [18:0] act;
    logic [8:0]  ract;
    @(posedge clk);
    #1;
    if (sbq.size() > 0) begin
      x = sbq.pop_front();
      case (x.id)
        0:       begin act = {e_a, d_a, rdy_a, err_a, busy_a};         ract = {rd_a, st_a}; end
        1:       begin act = {2'b00, e_b, d_b, rdy_b, err_b, busy_b};  ract = {rd_b, st_b}; end
        default: begin act = {e_c, d_c, rdy_c, err_c, busy_c};         ract = {rd_c, st_c}; end
      endcase
      chk($sformatf("dut%0d_wr{e,d,rdy,err,busy}", x.id), 32'(act),
          32'({x.e, x.d, x.rdy, x.err, !x.rdy}));
      if (x.chk_rd)
        chk($sformatf("dut%0d_rd{data,stale}", x.id), 32'(ract), 32'({x.rd, x.st}));
    end
  end

  task automatic drive(input int id, input logic v, input logic [2:0] a, input logic [7:0] d);
    case (id)
      0:       begin wv_a = v; wa_a = a; wd_a = d; end
      1:       begin wv_b = v; wa_b = a; wd_b = d; end
      default: begin wv_c = v; wa_c = a; wd_c = d; end
    endcase
  endtask

  // Issue one write at a negedge, queue the expected trace through the first
  // IDLE cycle and return on the negedge inside that IDLE cycle.
  task automatic wr(input int id, input logic [2:0] a, input logic [7:0] d,
                    input logic [7:0] oh, input logic er, input bit keep,
                    input bit chk_rd, input logic [7:0] old);
    int   s, w, h;
    exp_t x;
    if (id == 2) begin s = 3; w = 1; h = 2; end
    else         begin s = 1; w = 2; h = 1; end
    drive(id, 1'b1, a, d);
    for (int j = 0; j <= s + w + h; j++) begin
      x.id     = id;
      x.d      = d;
      x.e      = (j >= s && j < s + w) ? oh : 8'h00;
      x.rdy    = (j == s + w + h);
      x.err    = (j == 0) && er;
      x.chk_rd = chk_rd;
      x.rd     = (j >= s + 1) ? d : old;
      x.st     = (j >= 1);
      sbq.push_back(x);
    end
    @(negedge clk);
    if (!keep) drive(id, 1'b0, a, d);
    repeat (s + w + h) @(negedge clk);
  endtask

  task automatic idle_rd(input int id, input logic [7:0] d, input logic [7:0] rd);
    exp_t x;
    x.id = id; x.e = 8'h00; x.d = d; x.rdy = 1'b1; x.err = 1'b0;
    x.chk_rd = 1'b1; x.rd = rd; x.st = 1'b0;
    sbq.push_back(x);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 1'b0, 3'd0, 8'h00);
    drive(1, 1'b0, 3'd0, 8'h00);
    drive(2, 1'b0, 3'd0, 8'h00);
    ra_a = 3'd0; ra_b = 3'd0; ra_c = 3'd0;
    repeat (2) @(negedge clk);
    chk("reset_a", 32'({e_a, d_a, rdy_a, err_a, busy_a, rd_a, st_a}), 32'({8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0}));
    chk("reset_b", 32'({e_b, d_b, rdy_b, err_b, busy_b}), 32'({6'h00, 8'h00, 1'b1, 1'b0, 1'b0}));
    chk("reset_c", 32'({e_c, d_c, rdy_c, err_c, busy_c}), 32'({8'h00, 8'h00, 1'b1, 1'b0, 1'b0}));
    rst = 1'b0;
    @(negedge clk);

    // basic write, then back-to-back with WR_VALID held
    wr(0, 3'd3, 8'hA5, 8'h08, 1'b0, 1'b0, 1'b0, 8'h00);
    wr(0, 3'd0, 8'h11, 8'h01, 1'b0, 1'b1, 1'b0, 8'h00);
    wr(0, 3'd7, 8'hEE, 8'h80, 1'b0, 1'b0, 1'b0, 8'h00);

    // out-of-range write on DEPTH=6, then reads there
    wr(1, 3'd7, 8'hC3, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
    ra_b = 3'd7;
    idle_rd(1, 8'hC3, 8'h00);
    ra_b = 3'd5;
    idle_rd(1, 8'hC3, 8'hF5);

    // reset during PULSE
    drive(0, 1'b1, 3'd3, 8'h5A);
    @(negedge clk);
    drive(0, 1'b0, 3'd3, 8'h5A);
    @(negedge clk);
    chk("pulse_before_rst", 32'(e_a), 32'h08);
    rst = 1'b1;
    #1;
    chk("rst_async_lat_e", 32'(e_a), 32'h00);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("after_rst{rdy,busy,d,e}", 32'({rdy_a, busy_a, d_a, e_a}), 32'({1'b1, 1'b0, 8'h00, 8'h00}));
    repeat (3) @(negedge clk);
    chk("no_resume_lat_e", 32'(e_a), 32'h00);

    // read port on dut 0: stale during write to word 2, then steady reads
    ra_a = 3'd2;
    wr(0, 3'd2, 8'h3C, 8'h04, 1'b0, 1'b0, 1'b1, 8'h00);
    idle_rd(0, 8'h3C, 8'h3C);
    ra_a = 3'd3;
    idle_rd(0, 8'h3C, 8'h5A);

    // timing sweep on dut 2
    wr(2, 3'd4, 8'h96, 8'h10, 1'b0, 1'b0, 1'b0, 8'h00);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
